gx_wpar_gather_fifo: RTL and testbench
======================================

# gx_wpar_gather_fifo

- Parametrised successor to the GX write-gather pipe buffer.
- Accepts CPU-side 1-, 2- or 4-byte stores and packs them into a circular byte store of `BURSTS` × `BURST_BYTES`.
- Presents completed bursts to the command processor over a valid/ready handshake.
- Adds simultaneous push/pop, zero-pad flush, byte level, high-watermark and sticky overflow reporting.

## Interface

Parameters:
- `BURST_BYTES`, default 16: bytes per burst. Power of two, ≥4.
- `BURSTS`, default 2: burst slots. Power of two, ≥2.
- `HIWAT`, default 16: level threshold for `hiwat`. Range 1..`BURST_BYTES`×`BURSTS`.
- Derived: `BYTES` = `BURST_BYTES`×`BURSTS`; `LW` = clog2(`BYTES`)+1.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: store strobe.
- `wr_size` in 2: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = reserved.
- `wr_data` in 32: store data, right-justified.
- `flush` in 1: zero-pad the current partial burst.
- `clr_overflow` in 1: clears `overflow`.
- `burst_valid` out 1: a complete burst is available.
- `burst_ready` in 1: consumer accepts the burst.
- `burst_data` out `BURST_BYTES`×8: oldest complete burst.
- `level` out `LW`: bytes held.
- `full` out 1: `level` == `BYTES`.
- `hiwat` out 1: `level` ≥ `HIWAT`.
- `overflow` out 1: sticky; set when a store is dropped.

## Operation

Byte order:
- Bytes of one store enter in big-endian order.
  - 4 B: `wr_data[31:24]` first, then [23:16], [15:8], [7:0].
  - 2 B: [15:8] first, then [7:0].
  - 1 B: [7:0].
- The byte at burst offset k appears on `burst_data[8k+7:8k]`.

Pointers:
- Write pointer: `LW`-1 bits, byte granularity, wraps modulo `BYTES`.
- Read pointer: burst granularity, wraps modulo `BURSTS`.

Stores:
- n = store size in bytes.
- A store is accepted iff `wr_en`, `wr_size` ≠ 3, and `BYTES` − `level` ≥ n.
- The free-space check uses the registered `level`. A pop in the same cycle does not make room.
- A store may straddle a burst boundary; it continues into the next slot, wrapping at `BYTES`.
- A rejected store with size ≤ 4 B changes no state except `overflow` <= 1.
- `wr_size` = 3 is ignored: no write, no overflow.

Pop:
- A pop occurs when `burst_valid` and `burst_ready` are both high.
- The read pointer advances one burst and `level` decreases by `BURST_BYTES`.

Flush:
- Let p = (write pointer after this cycle's store) mod `BURST_BYTES`.
- If p ≠ 0: bytes p..`BURST_BYTES`−1 of that slot are written 0x00, the write pointer advances to the next boundary, and `level` increases by `BURST_BYTES`−p.
- If p = 0: no effect.
- Padding never needs free-space checking, because the slot is already partially owned.

Level and flags:
- `burst_valid` = (`level` ≥ `BURST_BYTES`).
- Same-cycle update: `level` <= `level` + accepted n + pad − (pop ? `BURST_BYTES` : 0). Evaluation order is store, then flush pad, then pop.
- `overflow` set has priority over `clr_overflow`.

## Timing

Reset:
- `level` = 0, both pointers = 0.
- `burst_valid` = 0, `full` = 0, `hiwat` = 0, `overflow` = 0.
- `burst_data` contents are don't-care.
- Reset mid-burst discards all data, partial bursts included. A flush or store in the reset cycle is ignored.

Latency:
- A store or flush in cycle N is reflected in `level`, `full`, `hiwat` and `burst_valid` in cycle N+1.
- The store or flush that completes a burst raises `burst_valid` at N+1.

Read side:
- `burst_data` is valid whenever `burst_valid` = 1. It is driven from the read slot (combinational from storage).
- `burst_data` must hold stable until the pop.
- After a pop at cycle N, the next burst is presented at N+1.

Throughput:
- One store (up to 4 B) and one pop per cycle, simultaneously.

## Test plan

1. Reset, then 16 × 1 B stores of 0x00..0x0F:
   - `burst_valid` rises the cycle after the 16th store.
   - `burst_data` = 0x0F0E0D0C0B0A09080706050403020100.
   - `level` = 16, `hiwat` = 1.
2. Straddle: at `level` 14, one 4 B store 0xAABBCCDD:
   - Burst0 bytes 14,15 = 0xAA,0xBB; burst1 bytes 0,1 = 0xCC,0xDD.
   - `level` = 18.
3. Full and overflow: fill to 32 with 4 B stores; a further 1 B store:
   - The store is dropped; `overflow` = 1, `level` = 32, `full` = 1.
   - `clr_overflow` clears `overflow` next cycle.
   - A simultaneous rejected store and `clr_overflow` leaves `overflow` = 1.
4. Flush: at `level` 5, pulse `flush`:
   - Next cycle `level` = 16 and `burst_valid` = 1.
   - Bytes 5..15 = 0x00; bytes 0..4 unchanged.
   - A second `flush` at a boundary changes nothing.
5. Simultaneous: at `level` 20 with `burst_ready` = 1, one 4 B store:
   - `level` = 8 next cycle; the popped burst matches the first 16 bytes written.
   - Pointer wrap across slot 1 → 0 is checked.
6. Reset mid-operation: `level` 21, `overflow` = 1, `reset` for one cycle:
   - All outputs return to reset values.
   - 16 fresh 1 B stores produce a burst containing only the new bytes.

Source files
------------

// File: rtl/gx_wpar_gather_fifo.sv
// gx_wpar_gather_fifo: write-gather FIFO that packs 1/2/4-byte CPU stores
// (big-endian byte order) into a circular byte store of BURSTS slots of
// BURST_BYTES each, and hands complete bursts to the consumer over a
// valid/ready handshake. Supports same-cycle store and pop, zero-pad flush
// of the partial burst, level/full/high-watermark flags and a sticky
// overflow flag for dropped stores.
module gx_wpar_gather_fifo #(
    parameter int BURST_BYTES = 16,
    parameter int BURSTS      = 2,
    parameter int HIWAT       = 16,
    localparam int BYTES      = BURST_BYTES * BURSTS,
    localparam int LW         = $clog2(BYTES) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [1:0]               wr_size,
    input  logic [31:0]              wr_data,
    input  logic                     flush,
    input  logic                     clr_overflow,
    output logic                     burst_valid,
    input  logic                     burst_ready,
    output logic [BURST_BYTES*8-1:0] burst_data,
    output logic [LW-1:0]            level,
    output logic                     full,
    output logic                     hiwat,
    output logic                     overflow
);

    // Pointer widths: byte-granular write pointer, slot-granular read pointer,
    // and the in-burst offset part of the write pointer.
    localparam int PW = LW - 1;
    localparam int OW = $clog2(BURST_BYTES);
    localparam int SW = PW - OW;

    logic [7:0]    mem [BYTES];
    logic [PW-1:0] wrPtr;
    logic [SW-1:0] rdPtr;
    logic [LW-1:0] levelQ;
    logic          overflowQ;

    logic [2:0]    storeLen;
    logic [31:0]   alignedData;
    logic          sizeOk;
    logic          storeFits;
    logic          storeAccept;
    logic          storeReject;
    logic [PW-1:0] ptrAfterStore;
    logic [OW-1:0] padStart;
    logic          padEn;
    logic [OW:0]   padLen;
    logic [PW-1:0] wrPtrNext;
    logic          pop;
    logic [LW-1:0] levelNext;

    // Decode the store size and left-justify the data so the first byte to
    // enter the buffer always sits in bits [31:24].
    always_comb begin
        storeLen    = 3'd0;
        alignedData = wr_data;
        case (wr_size)
            2'd0: begin
                storeLen    = 3'd1;
                alignedData = {wr_data[7:0], 24'h0};
            end
            2'd1: begin
                storeLen    = 3'd2;
                alignedData = {wr_data[15:0], 16'h0};
            end
            2'd2: begin
                storeLen    = 3'd4;
                alignedData = wr_data;
            end
            default: begin
                storeLen    = 3'd0;
                alignedData = wr_data;
            end
        endcase
    end

    // Accept/reject decision against the registered level, then flush padding
    // computed from where the write pointer lands after this cycle's store.
    always_comb begin
        sizeOk        = (wr_size != 2'd3);
        storeFits     = ((LW'(BYTES) - levelQ) >= LW'(storeLen));
        storeAccept   = wr_en && sizeOk && storeFits;
        storeReject   = wr_en && sizeOk && !storeFits;
        ptrAfterStore = wrPtr + (storeAccept ? PW'(storeLen) : '0);
        padStart      = ptrAfterStore[OW-1:0];
        padEn         = flush && (padStart != '0);
        padLen        = padEn ? ((OW+1)'(BURST_BYTES) - {1'b0, padStart}) : '0;
        wrPtrNext     = ptrAfterStore + PW'(padLen);
        pop           = burst_valid && burst_ready;
        levelNext     = levelQ
                      + (storeAccept ? LW'(storeLen) : '0)
                      + LW'(padLen)
                      - (pop ? LW'(BURST_BYTES) : '0);
    end

    // Byte storage: write the accepted store bytes, then zero the tail of the
    // partial slot on flush. The two ranges never overlap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (storeAccept && (3'(i) < storeLen)) begin
                    mem[wrPtr + PW'(i)] <= alignedData[31-8*i -: 8];
                end
            end
            for (int j = 0; j < BURST_BYTES; j++) begin
                if (padEn && (OW'(j) >= padStart)) begin
                    mem[{ptrAfterStore[PW-1:OW], OW'(j)}] <= 8'h00;
                end
            end
        end
    end

    // Pointers, level and sticky overflow; a dropped store outranks the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            levelQ    <= '0;
            overflowQ <= 1'b0;
        end else begin
            wrPtr  <= wrPtrNext;
            levelQ <= levelNext;
            if (pop) begin
                rdPtr <= rdPtr + SW'(1);
            end
            if (storeReject) begin
                overflowQ <= 1'b1;
            end else if (clr_overflow) begin
                overflowQ <= 1'b0;
            end
        end
    end

    // Present the read slot straight from storage, byte k on lane k.
    always_comb begin
        burst_data = '0;
        for (int k = 0; k < BURST_BYTES; k++) begin
            burst_data[8*k +: 8] = mem[{rdPtr, OW'(k)}];
        end
    end

    // Status flags derived from the registered level.
    always_comb begin
        level       = levelQ;
        burst_valid = (levelQ >= LW'(BURST_BYTES));
        full        = (levelQ == LW'(BYTES));
        hiwat       = (levelQ >= LW'(HIWAT));
        overflow    = overflowQ;
    end

endmodule

// File: tb/tb_gx_wpar_gather_fifo.sv
// tb_gx_wpar_gather_fifo: scoreboard bench. The stimulus side keeps a byte
// queue model of the FIFO and pushes completed bursts into an expected queue;
// a negedge monitor checks the flags every cycle and pops/compares a burst
// whenever a handshake is expected.
module tb_gx_wpar_gather_fifo;

    localparam int BB    = 16;
    localparam int NB    = 2;
    localparam int HW    = 16;
    localparam int BYTES = BB * NB;
    localparam int LW    = $clog2(BYTES) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [1:0]      wr_size;
    logic [31:0]     wr_data;
    logic            flush;
    logic            clr_overflow;
    logic            burst_valid;
    logic            burst_ready;
    logic [BB*8-1:0] burst_data;
    logic [LW-1:0]   level;
    logic            full;
    logic            hiwat;
    logic            overflow;

    // Reference model state.
    logic [7:0]      pending[$];
    logic [BB*8-1:0] expBursts[$];
    bit              ovfModel;

    // Expectations for the cycle currently being driven.
    int  expLevel;
    bit  expOvf;
    bit  expPop;
    bit  checkEn;
    int  vectors;
    int  miscompares;

    gx_wpar_gather_fifo #(
        .BURST_BYTES(BB),
        .BURSTS     (NB),
        .HIWAT      (HW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_size     (wr_size),
        .wr_data     (wr_data),
        .flush       (flush),
        .clr_overflow(clr_overflow),
        .burst_valid (burst_valid),
        .burst_ready (burst_ready),
        .burst_data  (burst_data),
        .level       (level),
        .full        (full),
        .hiwat       (hiwat),
        .overflow    (overflow)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic int modelLevel();
        return expBursts.size() * BB + pending.size();
    endfunction

    function automatic void pushByte(input logic [7:0] b);
        logic [BB*8-1:0] w;
        pending.push_back(b);
        if (pending.size() == BB) begin
            w = '0;
            for (int k = 0; k < BB; k++) w[8*k +: 8] = pending[k];
            expBursts.push_back(w);
            pending.delete();
        end
    endfunction

    task automatic checkOutput(input string name, input logic [BB*8-1:0] act,
                               input logic [BB*8-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, update the model, and advance past the edge.
    task automatic applyStimulus(input bit rst, input bit en, input logic [1:0] sz,
                                 input logic [31:0] d, input bit fl, input bit clr,
                                 input bit rdy);
        int n;
        bit rejected;
        reset        = rst;
        wr_en        = en;
        wr_size      = sz;
        wr_data      = d;
        flush        = fl;
        clr_overflow = clr;
        burst_ready  = rdy;
        expLevel     = modelLevel();
        expOvf       = ovfModel;
        expPop       = !rst && (expLevel >= BB) && rdy;
        rejected     = 1'b0;
        if (rst) begin
            pending.delete();
            expBursts.delete();
            ovfModel = 1'b0;
        end else begin
            n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
            if (en && sz != 2'd3) begin
                if (BYTES - expLevel >= n) begin
                    for (int i = 0; i < n; i++) pushByte(d[8*(n-1-i) +: 8]);
                end else begin
                    rejected = 1'b1;
                    ovfModel = 1'b1;
                end
            end
            if (!rejected && clr) ovfModel = 1'b0;
            if (fl) begin
                while (pending.size() != 0) pushByte(8'h00);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] d);
        applyStimulus(0, 1, sz, d, 0, 0, 0);
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(0, 0, 2'd0, 32'h0, 0, 0, rdy);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 2'd0, 32'h0, 0, 0, 0);
    endtask

    // Monitor: compare flags each cycle and pop/compare bursts on handshake.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("level", BB*8'(level), BB*8'(expLevel));
            checkOutput("full", BB*8'(full), BB*8'(expLevel == BYTES));
            checkOutput("hiwat", BB*8'(hiwat), BB*8'(expLevel >= HW));
            checkOutput("burst_valid", BB*8'(burst_valid), BB*8'(expLevel >= BB));
            checkOutput("overflow", BB*8'(overflow), BB*8'(expOvf));
            if (expPop) begin
                if (expBursts.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL burst_queue: got pop, expected no burst at %0t", $time);
                end else begin
                    checkOutput("burst_data", burst_data, expBursts.pop_front());
                end
            end
        end
    end

    // Directed scenarios from the test plan, then a randomized soak.
    initial begin
        vectors     = 0;
        miscompares = 0;
        checkEn     = 1'b0;
        ovfModel    = 1'b0;
        doReset();
        checkEn = 1'b1;
        doReset();

        // 16 single-byte stores 0x00..0x0F form one burst.
        for (int i = 0; i < 16; i++) store(2'd0, 32'(i));
        checkOutput("t1_data", burst_data, 128'h0F0E0D0C0B0A09080706050403020100);
        idle(1);
        idle(0);

        // 4-byte store straddling the slot boundary at level 14.
        doReset();
        for (int i = 0; i < 14; i++) store(2'd0, $urandom);
        store(2'd2, 32'hAABBCCDD);
        idle(1);
        applyStimulus(0, 0, 2'd0, 32'h0, 1, 0, 0);
        idle(1);
        idle(0);

        // Fill, overflow, clear, and overflow-vs-clear priority.
        doReset();
        for (int i = 0; i < 8; i++) store(2'd2, $urandom);
        store(2'd0, 32'h55);
        idle(0);
        applyStimulus(0, 0, 2'd0, 32'h0, 0, 1, 0);
        idle(0);
        applyStimulus(0, 1, 2'd0, 32'h66, 0, 1, 0);
        idle(1);
        idle(1);
        idle(0);

        // Flush at level 5, then a redundant flush on a boundary.
        doReset();
        for (int i = 0; i < 5; i++) store(2'd0, 32'h10 + 32'(i));
        applyStimulus(0, 0, 2'd0, 32'h0, 1, 0, 0);
        applyStimulus(0, 0, 2'd0, 32'h0, 1, 0, 0);
        idle(1);
        idle(0);

        // Store and pop in the same cycle, then wrap the write pointer.
        doReset();
        for (int i = 0; i < 5; i++) store(2'd2, $urandom);
        applyStimulus(0, 1, 2'd2, $urandom, 0, 0, 1);
        for (int i = 0; i < 4; i++) store(2'd2, $urandom);
        idle(1);
        for (int i = 0; i < 2; i++) store(2'd2, $urandom);
        idle(1);
        idle(0);

        // Reset in the middle of operation with overflow set.
        doReset();
        for (int i = 0; i < 8; i++) store(2'd2, $urandom);
        store(2'd0, 32'h77);
        idle(1);
        store(2'd2, $urandom);
        store(2'd0, $urandom);
        idle(0);
        doReset();
        for (int i = 0; i < 16; i++) store(2'd0, 32'hA0 + 32'(i));
        idle(1);
        idle(0);

        // Randomized soak.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom % 500) == 0, ($urandom % 4) != 0,
                          2'($urandom % 4), $urandom, ($urandom % 16) == 0,
                          ($urandom % 8) == 0, ($urandom % 2) == 0);
        end

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
